uart_cmd_rx: RTL and testbench

- Receive side of the BLE command UART: deserialises 8N1 frames from the host transmitter on RX.
- Buffers received bytes in a small FIFO and presents them to the Segway command decoder through a rdy/clr_rdy handshake.
- Replaces the bare single-byte receiver so that back-to-back commands (e.g. 'G' then 'S') are not lost while the decoder is busy.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/uart_cmd_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with a small byte FIFO and rdy/clr_rdy pop handshake.
// Define UART_PARITY_EN to receive 8E1 frames and expose the par_err pulse.
module uart_cmd_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RX,
  output logic [7:0]              rx_data,
  output logic                    rdy,
  input  logic                    clr_rdy,
  output logic [$clog2(DEPTH):0]  fifo_cnt,
  output logic                    frm_err,
  output logic                    ovr_err
`ifdef UART_PARITY_EN
  ,
  output logic                    par_err
`endif
);

  localparam int unsigned BaudW = $clog2(BAUD_DIV);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [BaudW-1:0] HalfBit = BaudW'(BAUD_DIV / 2);
  localparam logic [BaudW-1:0] FullBit = BaudW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0]  CntFull = CntW'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrk
  } state_e;

  // Synchroniser plus one delayed copy for falling-edge detection
  logic rx_meta_q, rx_s_q, rx_d1_q;
  logic rx_fall;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              tick;
  logic              push_req;
  logic              frm_q, frm_d;
  logic              ovr_q, ovr_d;
`ifdef UART_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              par_q, par_d;
`endif

  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              full, push, pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d1_q   <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_d1_q   <= rx_s_q;
    end
  end

  assign rx_fall = rx_d1_q & ~rx_s_q;
  assign tick    = (baud_q == '0);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frm_d     = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d = par_bad_q;
    par_d     = 1'b0;
`endif

    if (state_q == StStart || state_q == StData || state_q == StParity ||
        state_q == StStop) begin
      baud_d = tick ? FullBit : baud_q - BaudW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (rx_fall) begin
          state_d = StStart;
          baud_d  = HalfBit;
        end
      end
      StStart: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (tick) begin
          par_bad_d = rx_s_q ^ (^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
`ifdef UART_PARITY_EN
          par_d = par_bad_q;
`endif
          if (rx_s_q) begin
`ifdef UART_PARITY_EN
            push_req = ~par_bad_q;
`else
            push_req = 1'b1;
`endif
            state_d  = StIdle;
          end else begin
            frm_d   = 1'b1;
            state_d = StBrk;
          end
        end
      end
      StBrk: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q <= 1'b0;
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
`ifdef UART_PARITY_EN
      par_bad_q <= par_bad_d;
      par_q     <= par_d;
`endif
    end
  end

  // A pop on the same edge frees a slot, so a full FIFO can still accept
  assign full  = (cnt_q == CntFull);
  assign pop   = clr_rdy & rdy;
  assign push  = push_req & (~full | pop);
  assign ovr_d = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
    end
  end

  assign rx_data  = mem_q[rd_ptr_q];
  assign rdy      = (cnt_q != '0);
  assign fifo_cnt = cnt_q;
  assign frm_err  = frm_q;
  assign ovr_err  = ovr_q;
`ifdef UART_PARITY_EN
  assign par_err  = par_q;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial frames driven on RX, expected bytes
// queued when sent and compared when popped through clr_rdy.
module tb_uart_cmd_rx;

  localparam int unsigned B = 32;
  localparam int unsigned D = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   RX;
  logic                   clr_rdy;
  logic [7:0]             rx_data;
  logic                   rdy;
  logic [$clog2(D):0]     fifo_cnt;
  logic                   frm_err;
  logic                   ovr_err;
`ifdef UART_PARITY_EN
  logic                   par_err;
`endif

  uart_cmd_rx #(
    .BAUD_DIV (B),
    .DEPTH    (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .rx_data  (rx_data),
    .rdy      (rdy),
    .clr_rdy  (clr_rdy),
    .fifo_cnt (fifo_cnt),
    .frm_err  (frm_err),
    .ovr_err  (ovr_err)
`ifdef UART_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  int   cyc = 0;
  int   frm_n = 0;
  int   ovr_n = 0;
  int   par_n = 0;
  int   rise_cyc = 0;
  logic rdy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Counts high cycles of each error output, so one event must give exactly 1
  always @(negedge clk) begin
    if (frm_err) frm_n <= frm_n + 1;
    if (ovr_err) ovr_n <= ovr_n + 1;
`ifdef UART_PARITY_EN
    if (par_err) par_n <= par_n + 1;
`endif
    if (rdy && !rdy_prev) rise_cyc <= cyc;
    rdy_prev <= rdy;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] exp;
    exp = 32'hDEAD;
    if (exp_q.size() > 0) exp = {24'h0, exp_q.pop_front()};
    check({tag, " rdy"}, {31'h0, rdy}, 32'd1);
    check({tag, " data"}, {24'h0, rx_data}, exp);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  // Called at a negedge. The stop bit is sampled on the 20th posedge after it
  // is driven, so pop_at_stop lines clr_rdy up with that exact edge.
  task automatic send(input logic [7:0] b, input logic stop, input logic bad_par,
                      input logic pop_at_stop);
    logic [31:0] exp;
    RX = 1'b0;
    wait_neg(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_neg(B);
    end
`ifdef UART_PARITY_EN
    RX = (^b) ^ bad_par;
    wait_neg(B);
`endif
    RX = stop;
    for (int i = 0; i < int'(B); i++) begin
      if (pop_at_stop && i == 19) begin
        check("full before same-edge pop", {29'h0, fifo_cnt}, D);
        exp = 32'hDEAD;
        if (exp_q.size() > 0) exp = {24'h0, exp_q.pop_front()};
        check("same-edge pop data", {24'h0, rx_data}, exp);
        clr_rdy = 1'b1;
      end
      if (pop_at_stop && i == 20) begin
        clr_rdy = 1'b0;
        check("cnt after same-edge push/pop", {29'h0, fifo_cnt}, D);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [7:0] pb;
    int start_cyc, lat, f0, o0, p0;

    seq = '{8'h47, 8'h53, 8'h01, 8'hFF, 8'h00};
    RX = 1'b1;
    clr_rdy = 1'b0;
    rst = 1'b1;
    wait_neg(3);
    check("reset rdy", {31'h0, rdy}, 0);
    check("reset cnt", {29'h0, fifo_cnt}, 0);
    check("reset data", {24'h0, rx_data}, 0);
    check("reset frm", {31'h0, frm_err}, 0);
    check("reset ovr", {31'h0, ovr_err}, 0);
    rst = 1'b0;
    wait_neg(2 * B);

    // Single byte and latency
    start_cyc = cyc;
    send(8'h47, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h47);
    lat = rise_cyc - start_cyc;
    check("t1 rdy", {31'h0, rdy}, 1);
    check("t1 cnt", {29'h0, fifo_cnt}, 1);
    check("t1 latency window", {31'h0, (lat >= int'(9 * B)) && (lat <= int'(10 * B))}, 1);
    pop_check("t1 pop");
    check("t1 rdy after pop", {31'h0, rdy}, 0);
    check("t1 cnt after pop", {29'h0, fifo_cnt}, 0);

    // Overrun: fifth byte dropped, oldest kept
    o0 = ovr_n;
    for (int i = 0; i < 4; i++) begin
      send(seq[i], 1'b1, 1'b0, 1'b0);
      exp_q.push_back(seq[i]);
    end
    check("t2 cnt full", {29'h0, fifo_cnt}, D);
    send(seq[4], 1'b1, 1'b0, 1'b0);
    check("t2 ovr pulses", ovr_n - o0, 1);
    check("t2 cnt still full", {29'h0, fifo_cnt}, D);
    for (int i = 0; i < 4; i++) pop_check("t2 pop");
    check("t2 empty", {31'h0, rdy}, 0);

    // Full FIFO, push and pop on the same edge: no overrun
    o0 = ovr_n;
    for (int i = 0; i < 4; i++) begin
      send(seq[i], 1'b1, 1'b0, 1'b0);
      exp_q.push_back(seq[i]);
    end
    send(seq[4], 1'b1, 1'b0, 1'b1);
    exp_q.push_back(seq[4]);
    check("t3 no ovr", ovr_n - o0, 0);
    check("t3 cnt", {29'h0, fifo_cnt}, D);
    for (int i = 0; i < 4; i++) pop_check("t3 pop");
    check("t3 empty", {31'h0, rdy}, 0);

    // Framing error then held-low break
    f0 = frm_n;
    send(8'h55, 1'b0, 1'b0, 1'b0);
    RX = 1'b0;
    wait_neg(3 * B);
    check("t4 frm pulse", frm_n - f0, 1);
    check("t4 nothing pushed", {29'h0, fifo_cnt}, 0);
    RX = 1'b1;
    wait_neg(2 * B);
    check("t4 no retrigger", frm_n - f0, 1);
    send(8'h47, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h47);
    pop_check("t4 pop");

    // Short glitch is not a frame
    f0 = frm_n;
    o0 = ovr_n;
    RX = 1'b0;
    wait_neg(B / 4);
    RX = 1'b1;
    wait_neg(2 * B);
    check("t5 glitch rdy", {31'h0, rdy}, 0);
    check("t5 glitch frm", frm_n - f0, 0);
    check("t5 glitch ovr", ovr_n - o0, 0);

    // Reset mid-frame with a byte already buffered
    send(8'h81, 1'b1, 1'b0, 1'b0);
    check("t6 pre-reset rdy", {31'h0, rdy}, 1);
    pb = 8'hA5;
    RX = 1'b0;
    wait_neg(B);
    for (int i = 0; i < 4; i++) begin
      RX = pb[i];
      wait_neg(B);
    end
    rst = 1'b1;
    #1;
    check("t6 reset rdy", {31'h0, rdy}, 0);
    check("t6 reset cnt", {29'h0, fifo_cnt}, 0);
    check("t6 reset data", {24'h0, rx_data}, 0);
    check("t6 reset frm", {31'h0, frm_err}, 0);
    exp_q.delete();
    RX = 1'b1;
    wait_neg(2);
    rst = 1'b0;
    wait_neg(2 * B);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h3C);
    check("t6 cnt after reset", {29'h0, fifo_cnt}, 1);
    pop_check("t6 pop");

`ifdef UART_PARITY_EN
    p0 = par_n;
    send(8'h47, 1'b1, 1'b1, 1'b0);
    check("t7 par pulse", par_n - p0, 1);
    check("t7 discarded", {29'h0, fifo_cnt}, 0);
    send(8'h47, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h47);
    check("t7 good parity", par_n - p0, 1);
    pop_check("t7 pop");
`else
    p0 = par_n;
    check("no parity pulses", par_n - p0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
